// File: rtl/cia_pkg.sv
// Shared definitions for the CIA interval timer: count-source encoding and
// control-register bit positions. CIA_TIMER_PBOUT_EN widens the control
// register with the PB output controls.
package cia_pkg;

  typedef enum logic [1:0] {
    CIA_IN_PHI2     = 2'd0,
    CIA_IN_CNT      = 2'd1,
    CIA_IN_CASC     = 2'd2,
    CIA_IN_CASC_CNT = 2'd3
  } cia_inmode_e;

  localparam int CR_START     = 0;
  localparam int CR_ONESHOT   = 1;
  localparam int CR_FORCE     = 2;
  localparam int CR_INMODE_LO = 3;
  localparam int CR_INMODE_HI = 4;
`ifdef CIA_TIMER_PBOUT_EN
  localparam int CR_PBMODE    = 5;
  localparam int CR_PBON      = 6;
  localparam int CR_W         = 7;
`else
  localparam int CR_W         = 5;
`endif

endpackage

// File: rtl/cia_cnt_edge.sv
// CNT pin conditioning: two-flop synchroniser on clk followed by a
// rising-edge detector that compares the current and previous tick samples.
module cia_cnt_edge (
  input  logic clk,
  input  logic reset,
  input  logic phi2_en,
  input  logic cnt_pin,
  output logic cnt_hi,
  output logic cnt_rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of statement order.
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], cnt_pin};
  end

  // Remember the level seen at the previous PHI2 tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        prev_q <= 1'b0;
    else if (phi2_en) prev_q <= sync_q[1];
  end

  assign cnt_hi   = sync_q[1];
  assign cnt_rise = phi2_en & sync_q[1] & ~prev_q;

endmodule

// File: rtl/cia_timer_gen.sv
// CIA interval timer: WIDTH-bit down-counter with reload latch, one-shot and
// continuous modes, force-load, four count sources and an underflow pulse.
// Optional feature macro: CIA_TIMER_PBOUT_EN (adds pbmode/pbon and pb_out).
module cia_timer_gen
  import cia_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] LATCH_RST = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             phi2_en,
  input  logic             latch_wr,
  input  logic [WIDTH-1:0] latch_din,
  input  logic             cr_wr,
  input  logic [CR_W-1:0]  cr_din,
  input  logic             cnt_pin,
  input  logic             casc_in,
  output logic [WIDTH-1:0] count,
`ifdef CIA_TIMER_PBOUT_EN
  output logic             pb_out,
`endif
  output logic             underflow,
  output logic             running
);

  logic [WIDTH-1:0] latch_q, count_q;
  logic             start_q, oneshot_q, underflow_q;
  cia_inmode_e      inmode_q;

  // Writes that arrive between ticks wait here until the next tick.
  logic             pend_lw_q, pend_cw_q;
  logic [WIDTH-1:0] pend_lv_q;
  logic [CR_W-1:0]  pend_cv_q;

  logic             lw_eff, cw_eff;
  logic [WIDTH-1:0] lv_eff, latch_src;
  logic [CR_W-1:0]  cv_eff;
  logic             cnt_hi, cnt_rise;
  logic             ev, count_ev, force_ld, uf;

  logic [WIDTH-1:0] latch_n, count_n;
  logic             start_n, oneshot_n;
  cia_inmode_e      inmode_n;

  cia_cnt_edge u_cnt_edge (
    .clk      (clk),
    .reset    (reset),
    .phi2_en  (phi2_en),
    .cnt_pin  (cnt_pin),
    .cnt_hi   (cnt_hi),
    .cnt_rise (cnt_rise)
  );

  // Merge live and pending writes, pick the count event, decide this tick's action.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    lw_eff    = latch_wr | pend_lw_q;
    lv_eff    = latch_wr ? latch_din : pend_lv_q;
    cw_eff    = cr_wr | pend_cw_q;
    cv_eff    = cr_wr ? cr_din : pend_cv_q;
    latch_src = lw_eff ? lv_eff : latch_q;   // write-through on reload

    ev = 1'b0;
    unique case (inmode_q)
      CIA_IN_PHI2:     ev = 1'b1;
      CIA_IN_CNT:      ev = cnt_rise;
      CIA_IN_CASC:     ev = casc_in;
      CIA_IN_CASC_CNT: ev = casc_in & cnt_hi;
      default:         ev = 1'b0;
    endcase

    count_ev = start_q & ev;
    force_ld = cw_eff & cv_eff[CR_FORCE];
    uf       = count_ev & ~force_ld & (count_q == '0);

    latch_n   = latch_src;
    count_n   = count_q;
    start_n   = start_q;
    oneshot_n = oneshot_q;
    inmode_n  = inmode_q;

    if (force_ld || uf)          count_n = latch_src;
    else if (count_ev)           count_n = count_q - 1'b1;
    else if (lw_eff && !start_q) count_n = lv_eff;

    if (cw_eff) begin
      start_n   = cv_eff[CR_START];
      oneshot_n = cv_eff[CR_ONESHOT];
      inmode_n  = cia_inmode_e'(cv_eff[CR_INMODE_HI:CR_INMODE_LO]);
    end else if (uf && oneshot_q) begin
      start_n = 1'b0;
    end
  end

  // Timer state advances only on PHI2 ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_q   <= LATCH_RST;
      count_q   <= LATCH_RST;
      start_q   <= 1'b0;
      oneshot_q <= 1'b0;
      inmode_q  <= CIA_IN_PHI2;
    end else if (phi2_en) begin
      latch_q   <= latch_n;
      count_q   <= count_n;
      start_q   <= start_n;
      oneshot_q <= oneshot_n;
      inmode_q  <= inmode_n;
    end
  end

  // Hold off-tick writes; a tick consumes them, a newer write replaces them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_lw_q <= 1'b0;
      pend_cw_q <= 1'b0;
      pend_lv_q <= '0;
      pend_cv_q <= '0;
    end else if (phi2_en) begin
      pend_lw_q <= 1'b0;
      pend_cw_q <= 1'b0;
    end else begin
      if (latch_wr) begin
        pend_lw_q <= 1'b1;
        pend_lv_q <= latch_din;
      end
      if (cr_wr) begin
        pend_cw_q <= 1'b1;
        pend_cv_q <= cr_din;
      end
    end
  end

  // Underflow pulse lasts exactly the clk cycle after the underflow tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) underflow_q <= 1'b0;
    else       underflow_q <= phi2_en & uf;
  end

`ifdef CIA_TIMER_PBOUT_EN
  logic pbmode_q, pbon_q, toggle_q;

  // PB output controls and the underflow toggle flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pbmode_q <= 1'b0;
      pbon_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else if (phi2_en) begin
      if (cw_eff) begin
        pbmode_q <= cv_eff[CR_PBMODE];
        pbon_q   <= cv_eff[CR_PBON];
      end
      if (cw_eff && cv_eff[CR_START] && !start_q) toggle_q <= 1'b1;
      else if (uf)                                toggle_q <= ~toggle_q;
    end
  end

  assign pb_out = pbon_q & (pbmode_q ? toggle_q : underflow_q);
`endif

  assign count     = count_q;
  assign underflow = underflow_q;
  assign running   = start_q;

endmodule

// File: tb/tb_cia_timer_gen.sv
// Self-checking bench for cia_timer_gen: directed scenarios plus randomized
// tick gating checked against closed-form period arithmetic.
module tb_cia_timer_gen;
  import cia_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          phi2_en = 1'b1;
  logic          latch_wr = 1'b0;
  logic [W-1:0]  latch_din = '0;
  logic          cr_wr = 1'b0;
  logic [CR_W-1:0] cr_din = '0;
  logic          cnt_pin = 1'b0;
  logic          casc_in = 1'b0;
  logic [W-1:0]  count;
  logic          underflow, running;
`ifdef CIA_TIMER_PBOUT_EN
  logic          pb_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  cia_timer_gen #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .phi2_en   (phi2_en),
    .latch_wr  (latch_wr),
    .latch_din (latch_din),
    .cr_wr     (cr_wr),
    .cr_din    (cr_din),
    .cnt_pin   (cnt_pin),
    .casc_in   (casc_in),
    .count     (count),
`ifdef CIA_TIMER_PBOUT_EN
    .pb_out    (pb_out),
`endif
    .underflow (underflow),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clk cycle with the given tick enable; strobes are one cycle wide.
  task automatic do_tick(input logic en = 1'b1);
    phi2_en = en;
    @(posedge clk);
    #1;
    latch_wr = 1'b0;
    cr_wr    = 1'b0;
  endtask

  task automatic wr_latch(input int v);
    latch_wr = 1'b1; latch_din = W'(v);
    do_tick(1'b1);
  endtask

  task automatic wr_cr(input int v);
    cr_wr = 1'b1; cr_din = CR_W'(v);
    do_tick(1'b1);
  endtask

  task automatic wr_both(input int l, input int c);
    latch_wr = 1'b1; latch_din = W'(l);
    cr_wr = 1'b1; cr_din = CR_W'(c);
    do_tick(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l_val, k, e;
    logic en;

    // Reset state and idle ticks.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_count", 32'(count), 32'hFFFF);
    check("rst_running", 32'(running), 0);
    check("rst_underflow", 32'(underflow), 0);
    repeat (10) do_tick(1'b1);
    check("idle_count", 32'(count), 32'hFFFF);

    // Off-tick latch write is held until the next tick.
    latch_wr = 1'b1; latch_din = W'(9);
    do_tick(1'b0);
    repeat (3) do_tick(1'b0);
    check("pend_hold", 32'(count), 32'hFFFF);
    do_tick(1'b1);
    check("pend_apply", 32'(count), 9);

    // Continuous, PHI2 source, latch 3: period 4.
    wr_both(3, 1);
    check("cont_load", 32'(count), 3);
    for (int i = 1; i <= 12; i++) begin
      do_tick(1'b1);
      check($sformatf("cont_count_%0d", i), 32'(count), 32'(3 - i % 4));
      check($sformatf("cont_uf_%0d", i), 32'(underflow), 32'(i % 4 == 0));
    end
    wr_cr(0);

    // One-shot, latch 2.
    wr_both(2, 3);
    for (int i = 1; i <= 3; i++) begin
      do_tick(1'b1);
      check($sformatf("os_uf_%0d", i), 32'(underflow), 32'(i == 3));
    end
    check("os_count", 32'(count), 2);
    check("os_running", 32'(running), 0);
    repeat (3) do_tick(1'b1);
    check("os_idle_count", 32'(count), 2);
    check("os_idle_uf", 32'(underflow), 0);

    // CNT edge source.
    wr_both(10, 32'h09);
    for (int p = 0; p < 5; p++) begin
      cnt_pin = 1'b1; repeat (3) do_tick(1'b1);
      cnt_pin = 1'b0; repeat (3) do_tick(1'b1);
    end
    check("cnt_pulses", 32'(count), 5);
    cnt_pin = 1'b1; repeat (20) do_tick(1'b1);
    check("cnt_level", 32'(count), 4);
    cnt_pin = 1'b0;
    repeat (3) do_tick(1'b1);
    wr_cr(0);

    // Cascade source, latch 1, casc every 4th tick: underflow every 8 ticks.
    wr_both(1, 32'h11);
    for (int i = 0; i < 32; i++) begin
      casc_in = (i % 4 == 3);
      do_tick(1'b1);
      e = (i + 1) / 4;
      check($sformatf("casc_uf_%0d", i), 32'(underflow),
            32'((i % 4 == 3) && (e % 2 == 0)));
      check($sformatf("casc_count_%0d", i), 32'(count), 32'(1 - e % 2));
    end
    casc_in = 1'b0;
    wr_cr(32'h19);
    casc_in = 1'b1;
    repeat (16) do_tick(1'b1);
    casc_in = 1'b0;
    check("casc_cnt_low", 32'(count), 1);
    check("casc_cnt_low_uf", 32'(underflow), 0);
    wr_cr(0);

    // Force-load at count 0 on an event tick.
    wr_both(5, 1);
    repeat (5) do_tick(1'b1);
    check("fl_pre", 32'(count), 0);
    wr_cr(32'h05);
    check("fl_count", 32'(count), 5);
    check("fl_uf", 32'(underflow), 0);
    check("fl_running", 32'(running), 1);
    do_tick(1'b1);
    check("fl_next", 32'(count), 4);
    wr_cr(0);

    // Latch write landing on the reload tick is written through.
    wr_both(2, 1);
    repeat (2) do_tick(1'b1);
    check("wt_pre", 32'(count), 0);
    wr_latch(7);
    check("wt_count", 32'(count), 7);
    check("wt_uf", 32'(underflow), 1);
    do_tick(1'b1);
    check("wt_next", 32'(count), 6);

    // Asynchronous reset mid-count.
    #2 reset = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'hFFFF);
    check("arst_running", 32'(running), 0);
    @(posedge clk); #1 reset = 1'b0;
    do_tick(1'b1);
    check("arst_after", 32'(count), 32'hFFFF);

    // Randomized tick gating against period arithmetic.
    for (int it = 0; it < 6; it++) begin
      l_val = (it == 0) ? 0 : int'($urandom_range(1, 15));
      wr_cr(0);
      wr_both(l_val, 1);
      k = 0;
      for (int c = 0; c < 60; c++) begin
        en = 1'($urandom_range(0, 1));
        do_tick(en);
        if (en) k++;
        check($sformatf("rnd%0d_count_%0d", it, c), 32'(count),
              32'(l_val - k % (l_val + 1)));
        check($sformatf("rnd%0d_uf_%0d", it, c), 32'(underflow),
              32'(en && k > 0 && k % (l_val + 1) == 0));
      end
      phi2_en = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
